// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types for the GCD client and engine.
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} client_state_t;
endpackage

// File: rtl/gcd_client_if.sv
// gcd_client_if: request, response and engine handshake signals of the GCD client.
interface gcd_client_if #(
  parameter int nbits = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [nbits-1:0] req_a;
  logic [nbits-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [nbits-1:0] rsp_gcd;
  logic             rsp_timeout;
  logic [nbits-1:0] gcd_a;
  logic [nbits-1:0] gcd_b;
  logic             gcd_start;
  logic             gcd_done;
  logic [nbits-1:0] gcd_result;
  modport master (
    input  req_valid, req_a, req_b, rsp_ready, gcd_done, gcd_result,
    output req_ready, rsp_valid, rsp_gcd, rsp_timeout, gcd_a, gcd_b, gcd_start
  );
  modport slave (
    output req_valid, req_a, req_b, rsp_ready, gcd_done, gcd_result,
    input  req_ready, rsp_valid, rsp_gcd, rsp_timeout, gcd_a, gcd_b, gcd_start
  );
endinterface

// File: rtl/gcd_req_fifo.sv
// gcd_req_fifo: small registered FIFO of {a,b} operand pairs.
module gcd_req_fifo #(
  parameter int nbits = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [2*nbits-1:0] din,
  output logic               full,
  output logic               empty,
  output logic [2*nbits-1:0] dout
);
  localparam int aw = $clog2(DEPTH);
  logic [2*nbits-1:0] mem [DEPTH];
  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;
  logic [aw:0]        count;
  logic               push_ok;
  logic               pop_ok;
  assign full    = count == (aw+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (aw+1)'(push_ok) - (aw+1)'(pop_ok);
    end
  // Storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/gcd_client.sv
// gcd_client: queues operand pairs, drives the GCD engine start/done handshake and returns results with a watchdog.
module gcd_client
  import gcd_pkg::*;
#(
  parameter int nbits          = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           reset,
  gcd_client_if.master  bus
);
  localparam int cw = $clog2(TIMEOUT_CYCLES + 1);
  client_state_t      state;
  logic               orphan;
  logic               full;
  logic               empty;
  logic               pop;
  logic [cw-1:0]      count;
  logic [2*nbits-1:0] dout;
  assign bus.req_ready = !full;
  // A timed-out engine may still be busy; hold off new starts until its late done drains.
  assign pop = state == IDLE && !empty && !orphan;
  gcd_req_fifo #(.nbits(nbits), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.req_valid && !full),
    .pop   (pop),
    .din   ({bus.req_a, bus.req_b}),
    .full  (full),
    .empty (empty),
    .dout  (dout)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state           <= IDLE;
      orphan          <= 1'b0;
      count           <= '0;
      bus.gcd_start   <= 1'b0;
      bus.gcd_a       <= '0;
      bus.gcd_b       <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_gcd     <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      if (bus.gcd_done) orphan <= 1'b0;
      case (state)
        IDLE:
          if (pop) begin
            bus.gcd_a     <= dout[2*nbits-1:nbits];
            bus.gcd_b     <= dout[nbits-1:0];
            bus.gcd_start <= 1'b1;
            state         <= ISSUE;
          end
        ISSUE: begin
          bus.gcd_start <= 1'b0;
          count         <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          count <= count + 1'b1;
          // Done takes priority over a watchdog expiry in the same cycle.
          if (bus.gcd_done) begin
            bus.rsp_gcd     <= bus.gcd_result;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else if (count == cw'(TIMEOUT_CYCLES - 1)) begin
            bus.rsp_gcd     <= '0;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            orphan          <= 1'b1;
            state           <= RESP;
          end
        end
        RESP:
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gcd_client.sv
// tb_gcd_client: directed vectors for gcd_client against a behavioural engine with a stub mode.
module tb_gcd_client;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_starts = 0;
  int   eng_delay = 3;
  int   eng_left = 0;
  bit   eng_stub = 1'b0;
  logic [31:0] eng_val = '0;
  logic [31:0] ea = '0;
  logic [31:0] eb = '0;

  always #5 clk = ~clk;

  gcd_client_if #(.nbits(32)) bus ();
  gcd_client #(.nbits(32), .DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a;
    logic [31:0] y = b;
    logic [31:0] t;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // Engine: done arrives eng_delay+1 cycles after the start cycle.
  always @(posedge clk) begin
    bus.gcd_done <= 1'b0;
    if (bus.gcd_start === 1'b1) begin
      ea       <= bus.gcd_a;
      eb       <= bus.gcd_b;
      eng_left <= eng_delay;
    end else if (eng_left > 0) begin
      eng_left <= eng_left - 1;
      if (eng_left == 1) begin
        bus.gcd_done   <= 1'b1;
        bus.gcd_result <= eng_stub ? eng_val : gcd_ref(ea, eb);
      end
    end
  end

  always @(posedge clk)
    if (bus.gcd_start === 1'b1) n_starts++;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    while (bus.req_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) expect_eq("send_ready", 32'(bus.req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [31:0] g, input logic to);
    int t = 0;
    while (bus.rsp_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    expect_eq({tag, "_valid"}, 32'(bus.rsp_valid), 1);
    expect_eq({tag, "_gcd"}, bus.rsp_gcd, g);
    expect_eq({tag, "_timeout"}, 32'(bus.rsp_timeout), 32'(to));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int seen;
    int vseen;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    expect_eq("rst_start", 32'(bus.gcd_start), 0);
    expect_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    expect_eq("rst_rsp_timeout", 32'(bus.rsp_timeout), 0);
    expect_eq("rst_rsp_gcd", bus.rsp_gcd, 0);
    expect_eq("rst_gcd_a", bus.gcd_a, 0);
    expect_eq("rst_gcd_b", bus.gcd_b, 0);
    reset = 1'b0;
    @(negedge clk);
    expect_eq("rst_req_ready", 32'(bus.req_ready), 1);

    // Basic latency and operand hold
    send(48, 18);
    expect_eq("basic_start_n1", 32'(bus.gcd_start), 0);
    @(negedge clk);
    expect_eq("basic_start_n2", 32'(bus.gcd_start), 1);
    expect_eq("basic_gcd_a", bus.gcd_a, 48);
    expect_eq("basic_gcd_b", bus.gcd_b, 18);
    @(negedge clk);
    expect_eq("basic_start_n3", 32'(bus.gcd_start), 0);
    expect_eq("basic_hold_a", bus.gcd_a, 48);
    expect_eq("basic_hold_b", bus.gcd_b, 18);
    recv("basic", 6, 1'b0);
    expect_eq("basic_starts", n_starts, 1);

    // Zero operands and coprime, back to back
    send(7, 0);
    send(0, 5);
    send(17, 5);
    recv("zero_b", 7, 1'b0);
    recv("zero_a", 5, 1'b0);
    recv("coprime", 1, 1'b0);

    // Back-pressure: one in flight plus four buffered
    send(12, 8);
    send(9, 6);
    send(100, 75);
    send(14, 21);
    expect_eq("bp_ready_4", 32'(bus.req_ready), 1);
    send(35, 49);
    expect_eq("bp_ready_5", 32'(bus.req_ready), 0);
    fork
      send(81, 27);
      begin
        recv("bp1", 4, 1'b0);
        recv("bp2", 3, 1'b0);
        recv("bp3", 25, 1'b0);
        recv("bp4", 7, 1'b0);
        recv("bp5", 7, 1'b0);
      end
    join
    recv("bp6", 27, 1'b0);

    // Watchdog timeout with a late done
    eng_stub  = 1'b1;
    eng_val   = 99;
    eng_delay = 19;
    send(30, 12);
    send(10, 4);
    recv("to", 0, 1'b1);
    expect_eq("to_orphan_set", 32'(dut.orphan), 1);
    base = n_starts;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.gcd_done === 1'b1) seen = 1;
    end
    expect_eq("to_late_done", seen, 1);
    expect_eq("to_no_start", n_starts, base);
    eng_stub  = 1'b0;
    eng_delay = 3;
    recv("after_to", 2, 1'b0);
    expect_eq("after_to_orphan", 32'(dut.orphan), 0);

    // Done on the last watchdog cycle
    eng_stub  = 1'b1;
    eng_val   = 55;
    eng_delay = 7;
    send(8, 12);
    recv("sim", 55, 1'b0);
    expect_eq("sim_orphan", 32'(dut.orphan), 0);
    eng_stub  = 1'b0;
    eng_delay = 3;
    send(21, 14);
    recv("after_sim", 7, 1'b0);

    // Asynchronous reset mid-WAIT with three queued
    eng_delay = 6;
    send(2, 4);
    send(3, 9);
    send(5, 10);
    send(6, 8);
    expect_eq("mid_state_wait", 32'(dut.state), 2);
    #1 reset = 1'b1;
    #1;
    expect_eq("mid_rst_state", 32'(dut.state), 0);
    expect_eq("mid_rst_empty", 32'(dut.empty), 1);
    expect_eq("mid_rst_start", 32'(bus.gcd_start), 0);
    expect_eq("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    expect_eq("mid_rst_rsp_gcd", bus.rsp_gcd, 0);
    expect_eq("mid_rst_gcd_a", bus.gcd_a, 0);
    expect_eq("mid_rst_gcd_b", bus.gcd_b, 0);
    @(negedge clk);
    reset = 1'b0;
    base  = n_starts;
    vseen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) vseen = 1;
    end
    expect_eq("post_rst_no_valid", vseen, 0);
    expect_eq("post_rst_no_start", n_starts, base);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
